cgra0_run_ctrl: RTL and testbench

Top-level sequencer for one CGRA instance. It streams configuration words from the host onto the 64-bit broadcast configuration bus read by every PE's configuration reader. It then drives the global `en` that advances all PE pipelines and thread counters, gating it on input-queue availability and output-queue backpressure. It counts output writes and reports completion.

---
 rtl/cgra0_ctrl_pkg.sv | 13 +
 rtl/cgra0_run_ctrl_if.sv | 38 +++
 rtl/cgra0_out_counter.sv | 32 +++
 rtl/cgra0_run_ctrl.sv | 110 +++++++++++
 tb/tb_cgra0_run_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cgra0_ctrl_pkg.sv
// Shared types and constants for the CGRA run controller.
// State encoding and configuration bus definitions.
package cgra0_ctrl_pkg;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONF = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   localparam int CONF_BUS_WIDTH = 64;
   localparam logic [CONF_BUS_WIDTH-1:0] CONF_NOP = 64'd0;
endpackage

// File: rtl/cgra0_run_ctrl_if.sv
// Host/PE-facing signal bundle of the CGRA run controller.
// The host side drives the master modport, the controller is the slave.
interface cgra0_run_ctrl_if #(
   parameter int NUM_IN    = 4,
   parameter int NUM_OUT   = 4,
   parameter int CNT_WIDTH = 32
);
   import cgra0_ctrl_pkg::*;

   logic                      start;
   logic [15:0]               conf_num;
   logic [NUM_IN-1:0]         in_mask;
   logic [CNT_WIDTH-1:0]      out_target;
   logic                      conf_valid;
   logic                      conf_ready;
   logic [CONF_BUS_WIDTH-1:0] conf_data;
   logic [CONF_BUS_WIDTH-1:0] conf_bus_out;
   logic [NUM_IN-1:0]         in_avail;
   logic [NUM_OUT-1:0]        out_afull;
   logic [NUM_OUT-1:0]        out_we;
   logic                      en;
   logic                      busy;
   logic                      done;

   modport master (
      output start, conf_num, in_mask, out_target,
      output conf_valid, conf_data,
      output in_avail, out_afull, out_we,
      input  conf_ready, conf_bus_out, en, busy, done
   );

   modport slave (
      input  start, conf_num, in_mask, out_target,
      input  conf_valid, conf_data,
      input  in_avail, out_afull, out_we,
      output conf_ready, conf_bus_out, en, busy, done
   );
endinterface

// File: rtl/cgra0_out_counter.sv
// Saturating write counter for one output queue.
// Also reports whether the limit will be met after this cycle's update.
module cgra0_out_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_inc,
   input  logic [W-1:0] i_limit,
   output logic         o_reached,
   output logic         o_reached_nxt
);
   logic [W-1:0] r_cnt;
   logic [W-1:0] w_cnt_inc;
   logic         w_step;

   assign w_cnt_inc     = r_cnt + W'(1);
   assign o_reached     = (r_cnt == i_limit);
   assign w_step        = i_inc & ~o_reached;
   assign o_reached_nxt = o_reached | (w_step & (w_cnt_inc == i_limit));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (w_step) begin
         r_cnt <= w_cnt_inc;
      end
   end
endmodule

// File: rtl/cgra0_run_ctrl.sv
// CGRA run sequencer: streams config words, gates global enable,
// counts output writes and signals completion.
module cgra0_run_ctrl
   import cgra0_ctrl_pkg::*;
#(
   parameter int NUM_IN    = 4,
   parameter int NUM_OUT   = 4,
   parameter int CNT_WIDTH = 32
) (
   input logic             clk,
   input logic             rst,
   cgra0_run_ctrl_if.slave bus
);
   state_e                    r_state;
   logic                      r_busy;
   logic                      r_done;
   logic                      r_conf_ready;
   logic [CONF_BUS_WIDTH-1:0] r_conf_bus;
   logic [15:0]               r_word_cnt;
   logic [15:0]               r_conf_num;
   logic [NUM_IN-1:0]         r_in_mask;
   logic [CNT_WIDTH-1:0]      r_target;

   logic                      w_start;
   logic                      w_accept;
   logic                      w_last;
   logic                      w_run;
   logic                      w_gate;
   logic [NUM_OUT-1:0]        w_reach;
   logic [NUM_OUT-1:0]        w_reach_nxt;

   assign w_start  = bus.start & (r_state == S_IDLE);
   assign w_accept = r_conf_ready & bus.conf_valid;
   assign w_last   = w_accept & ((r_word_cnt + 16'd1) == r_conf_num);
   assign w_run    = (r_state == S_RUN);
   assign w_gate   = (&(bus.in_avail | ~r_in_mask)) & ~(|bus.out_afull);

   for (genvar i = 0; i < NUM_OUT; i++) begin : g_cnt
      cgra0_out_counter #(.W(CNT_WIDTH)) u_cnt (
         .clk           (clk),
         .rst           (rst),
         .i_clr         (w_start),
         .i_inc         (w_run & bus.out_we[i]),
         .i_limit       (r_target),
         .o_reached     (w_reach[i]),
         .o_reached_nxt (w_reach_nxt[i])
      );
   end

   // Enable stays low once every queue has its quota (covers zero targets).
   assign bus.en           = w_run & ~(&w_reach) & w_gate;
   assign bus.conf_ready   = r_conf_ready;
   assign bus.conf_bus_out = r_conf_bus;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_conf_ready <= 1'b0;
         r_conf_bus   <= CONF_NOP;
         r_word_cnt   <= '0;
         r_conf_num   <= '0;
         r_in_mask    <= '0;
         r_target     <= '0;
      end else begin
         r_conf_bus <= w_accept ? bus.conf_data : CONF_NOP;
         if (w_accept) begin
            r_word_cnt <= r_word_cnt + 16'd1;
         end
         unique case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_conf_num <= bus.conf_num;
                  r_in_mask  <= bus.in_mask;
                  r_target   <= bus.out_target;
                  r_word_cnt <= '0;
                  r_busy     <= 1'b1;
                  if (bus.conf_num != 16'd0) begin
                     r_state      <= S_CONF;
                     r_conf_ready <= 1'b1;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_CONF: begin
               if (w_last) begin
                  r_state      <= S_RUN;
                  r_conf_ready <= 1'b0;
               end
            end
            S_RUN: begin
               if (&w_reach_nxt) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cgra0_run_ctrl.sv
// Self-checking bench for cgra0_run_ctrl: directed tables, hand
// sequences and a randomized run against a transaction-level model.
module tb_cgra0_run_ctrl;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   cgra0_run_ctrl_if #(.NUM_IN(4), .NUM_OUT(4), .CNT_WIDTH(32)) bus ();

   cgra0_run_ctrl #(.NUM_IN(4), .NUM_OUT(4), .CNT_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] mask;
      logic [3:0] avail;
      logic [3:0] afull;
      logic       en;
   } gate_vec_t;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start      = 1'b0;
      bus.conf_num   = 16'd0;
      bus.in_mask    = 4'd0;
      bus.out_target = 32'd0;
      bus.conf_valid = 1'b0;
      bus.conf_data  = 64'd0;
      bus.in_avail   = 4'd0;
      bus.out_afull  = 4'd0;
      bus.out_we     = 4'd0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      cyc();
      rst = 1'b1;
      cyc();
   endtask

   task automatic kick(input logic [15:0] n, input logic [3:0] m,
                       input logic [31:0] tgt);
      bus.start      = 1'b1;
      bus.conf_num   = n;
      bus.in_mask    = m;
      bus.out_target = tgt;
      cyc();
      bus.start = 1'b0;
   endtask

   // Transaction-level reference for the random phase
   int          m_ph;
   int          m_left;
   int          m_tgt;
   logic [3:0]  m_mask;
   int          m_cnt [4];
   logic [63:0] m_bus;

   function automatic bit m_all_met();
      for (int i = 0; i < 4; i++)
         if (m_cnt[i] != m_tgt) return 1'b0;
      return 1'b1;
   endfunction

   gate_vec_t gv [8];

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      idle_inputs();

      // Reset with random inputs: every output low, even without a clock edge
      bus.start      = 1'b1;
      bus.conf_num   = 16'(($urandom % 7) + 1);
      bus.conf_valid = 1'b1;
      bus.conf_data  = {$urandom, $urandom};
      bus.in_avail   = 4'($urandom);
      bus.out_we     = 4'($urandom);
      #2;
      chk("rst_ready", 64'(bus.conf_ready), 64'd0);
      chk("rst_bus", bus.conf_bus_out, 64'd0);
      chk("rst_en", 64'(bus.en), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      cyc();
      cyc();
      chk("rst_hold_busy", 64'(bus.busy), 64'd0);
      chk("rst_hold_bus", bus.conf_bus_out, 64'd0);

      // Idle with conf_valid held: no acknowledge, nothing on the bus
      idle_inputs();
      bus.conf_valid = 1'b1;
      bus.conf_data  = 64'hDEAD_BEEF_0000_0001;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("idle_ready", 64'(bus.conf_ready), 64'd0);
         chk("idle_bus", bus.conf_bus_out, 64'd0);
      end

      // Configuration stream A, bubble, B, C
      idle_inputs();
      kick(16'd3, 4'd0, 32'd1);
      chk("cf_busy", 64'(bus.busy), 64'd1);
      chk("cf_ready", 64'(bus.conf_ready), 64'd1);
      bus.conf_valid = 1'b1;
      bus.conf_data  = 64'hAAAA_0000_0000_000A;
      cyc();
      chk("cf_busA", bus.conf_bus_out, 64'hAAAA_0000_0000_000A);
      bus.conf_valid = 1'b0;
      bus.conf_data  = 64'h1111_1111_1111_1111;
      cyc();
      chk("cf_bus_bubble", bus.conf_bus_out, 64'd0);
      chk("cf_ready_mid", 64'(bus.conf_ready), 64'd1);
      bus.conf_valid = 1'b1;
      bus.conf_data  = 64'hBBBB_0000_0000_000B;
      cyc();
      chk("cf_busB", bus.conf_bus_out, 64'hBBBB_0000_0000_000B);
      bus.conf_data = 64'hCCCC_0000_0000_000C;
      cyc();
      chk("cf_busC", bus.conf_bus_out, 64'hCCCC_0000_0000_000C);
      chk("cf_ready_drop", 64'(bus.conf_ready), 64'd0);
      chk("cf_run_en", 64'(bus.en), 64'd1);
      bus.conf_valid = 1'b1;
      bus.out_we     = 4'b1111;
      cyc();
      chk("cf_bus_after", bus.conf_bus_out, 64'd0);
      chk("cf_done", 64'(bus.done), 64'd1);
      chk("cf_done_en", 64'(bus.en), 64'd0);
      idle_inputs();
      cyc();
      chk("cf_idle_busy", 64'(bus.busy), 64'd0);
      chk("cf_idle_done", 64'(bus.done), 64'd0);

      // No configuration, zero target: IDLE->RUN->DONE with en never high
      bus.in_avail = 4'b1111;
      bus.out_we   = 4'b1111;
      kick(16'd0, 4'b1111, 32'd0);
      chk("nc_busy", 64'(bus.busy), 64'd1);
      chk("nc_run_en", 64'(bus.en), 64'd0);
      chk("nc_run_done", 64'(bus.done), 64'd0);
      chk("nc_ready", 64'(bus.conf_ready), 64'd0);
      cyc();
      chk("nc_done", 64'(bus.done), 64'd1);
      chk("nc_done_en", 64'(bus.en), 64'd0);
      cyc();
      chk("nc_idle_busy", 64'(bus.busy), 64'd0);
      chk("nc_idle_done", 64'(bus.done), 64'd0);

      // Input gating / backpressure table
      gv[0] = '{4'b0101, 4'b1110, 4'b0000, 1'b0};
      gv[1] = '{4'b0101, 4'b1111, 4'b0000, 1'b1};
      gv[2] = '{4'b0101, 4'b0111, 4'b0000, 1'b1};
      gv[3] = '{4'b0000, 4'b0000, 4'b0000, 1'b1};
      gv[4] = '{4'b0000, 4'b1111, 4'b0100, 1'b0};
      gv[5] = '{4'b1111, 4'b1110, 4'b0000, 1'b0};
      gv[6] = '{4'b1111, 4'b1111, 4'b1000, 1'b0};
      gv[7] = '{4'b1010, 4'b1010, 4'b0000, 1'b1};
      for (int v = 0; v < 8; v++) begin
         do_reset();
         kick(16'd0, gv[v].mask, 32'd100);
         bus.in_avail  = gv[v].avail;
         bus.out_afull = gv[v].afull;
         #1;
         chk($sformatf("gate%0d", v), 64'(bus.en), 64'(gv[v].en));
      end

      // Same-cycle response of en to in_avail changes
      do_reset();
      kick(16'd0, 4'b0101, 32'd100);
      bus.in_avail = 4'b1110;
      #1;
      chk("gs_off", 64'(bus.en), 64'd0);
      bus.in_avail = 4'b1111;
      #1;
      chk("gs_on", 64'(bus.en), 64'd1);
      bus.in_avail = 4'b0111;
      #1;
      chk("gs_unmasked", 64'(bus.en), 64'd1);

      // Backpressure toggling and completion on the slowest queue
      do_reset();
      kick(16'd0, 4'd0, 32'd4);
      for (int k = 0; k < 4; k++) begin
         bus.out_afull = (k % 2 == 0) ? 4'b0100 : 4'b0000;
         #1;
         chk("bp_en", 64'(bus.en), (k % 2 == 0) ? 64'd0 : 64'd1);
         cyc();
      end
      bus.out_afull = 4'd0;
      for (int k = 0; k < 5; k++) begin
         bus.out_we = (k < 3) ? 4'b1111 : 4'b1011;
         cyc();
         chk("bp_notdone", 64'(bus.done), 64'd0);
         chk("bp_en_run", 64'(bus.en), 64'd1);
      end
      bus.out_we = 4'b0100;
      cyc();
      chk("bp_done", 64'(bus.done), 64'd1);
      chk("bp_done_en", 64'(bus.en), 64'd0);
      bus.out_we = 4'b1111;
      cyc();
      chk("bp_idle", 64'(bus.busy), 64'd0);
      idle_inputs();

      // Abort by reset in RUN, then restart from clean counters
      kick(16'd0, 4'd0, 32'd3);
      bus.out_we = 4'b1111;
      cyc();
      chk("ab_en_before", 64'(bus.en), 64'd1);
      bus.out_we = 4'd0;
      #2;
      rst = 1'b0;
      #1;
      chk("ab_en_async", 64'(bus.en), 64'd0);
      chk("ab_busy_async", 64'(bus.busy), 64'd0);
      cyc();
      rst = 1'b1;
      cyc();
      kick(16'd1, 4'd0, 32'd2);
      bus.conf_valid = 1'b1;
      bus.conf_data  = 64'h0123_4567_89AB_CDEF;
      cyc();
      chk("rs_bus", bus.conf_bus_out, 64'h0123_4567_89AB_CDEF);
      bus.conf_valid = 1'b0;
      bus.out_we     = 4'b1111;
      cyc();
      chk("rs_notdone", 64'(bus.done), 64'd0);
      chk("rs_en", 64'(bus.en), 64'd1);
      cyc();
      chk("rs_done", 64'(bus.done), 64'd1);
      idle_inputs();
      cyc();
      chk("rs_idle", 64'(bus.busy), 64'd0);

      // Randomized run against the reference model
      do_reset();
      m_ph   = 0;
      m_left = 0;
      m_tgt  = 0;
      m_mask = 4'd0;
      m_bus  = 64'd0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         bus.start      = ($urandom % 4) == 0;
         bus.conf_num   = 16'($urandom % 5);
         bus.in_mask    = 4'($urandom);
         bus.out_target = 32'($urandom % 6);
         bus.conf_valid = ($urandom % 3) != 0;
         bus.conf_data  = {$urandom, $urandom};
         bus.in_avail   = 4'($urandom) | 4'($urandom);
         bus.out_afull  = (($urandom % 4) == 0) ? 4'($urandom) : 4'd0;
         bus.out_we     = 4'($urandom);
         #1;
         chk("rnd_busy", 64'(bus.busy), 64'(m_ph != 0));
         chk("rnd_ready", 64'(bus.conf_ready), 64'(m_ph == 1));
         chk("rnd_done", 64'(bus.done), 64'(m_ph == 3));
         chk("rnd_bus", bus.conf_bus_out, m_bus);
         chk("rnd_en", 64'(bus.en),
             64'((m_ph == 2) && !m_all_met() &&
                 ((&(bus.in_avail | ~m_mask)) && (bus.out_afull == 4'd0))));
         m_bus = 64'd0;
         case (m_ph)
            0: if (bus.start) begin
               m_left = int'(bus.conf_num);
               m_tgt  = int'(bus.out_target);
               m_mask = bus.in_mask;
               for (int i = 0; i < 4; i++) m_cnt[i] = 0;
               m_ph = (m_left != 0) ? 1 : 2;
            end
            1: if (bus.conf_valid) begin
               m_bus  = bus.conf_data;
               m_left = m_left - 1;
               if (m_left == 0) m_ph = 2;
            end
            2: begin
               for (int i = 0; i < 4; i++)
                  if (bus.out_we[i] && m_cnt[i] < m_tgt) m_cnt[i]++;
               if (m_all_met()) m_ph = 3;
            end
            default: m_ph = 0;
         endcase
         @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
